// File: rtl/tx_serial_arbitro_pkg.sv
// Shared types and constants for the tx_serial_arbitro transmitter-sharing arbiter.
// The state codes double as the db_estado value shown on the hexa7seg display.
package tx_serial_arbitro_pkg;

  localparam int NUM_REQ               = 4;
  localparam int TIMEOUT_CICLOS_PADRAO = 65536;

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    PARTIDA = 4'd1,
    ESPERA  = 4'd2,
    FIM     = 4'd3,
    ERRO    = 4'd4
  } estado_t;

  typedef logic [$clog2(NUM_REQ)-1:0] indice_t;

  function automatic logic [NUM_REQ-1:0] um_quente(input indice_t i);
    return NUM_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/tx_serial_arbitro_if.sv
// Requester and transmitter handshake bundle around the arbiter.
// master is the arbiter side; slave is the requesters plus the transmitter.
interface tx_serial_arbitro_if;
  import tx_serial_arbitro_pkg::*;

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] dados;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   ack;
  logic [NUM_REQ-1:0]   erro;
  logic                 tx_partida;
  logic [7:0]           tx_dados;
  logic                 tx_pronto;

  modport master (
    input  req, dados, tx_pronto,
    output grant, ack, erro, tx_partida, tx_dados
  );

  modport slave (
    output req, dados, tx_pronto,
    input  grant, ack, erro, tx_partida, tx_dados
  );

endinterface

// File: rtl/tx_serial_arbitro_sel.sv
// Combinational round-robin pick: first asserted request scanning upward from ptr,
// wrapping modulo NUM_REQ.
module arbitro_rr_sel
  import tx_serial_arbitro_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  indice_t            ptr,
  output indice_t            vencedor,
  output logic               valido
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path leaves it unassigned and no latch appears.
  always_comb begin
    vencedor = ptr;
    valido   = 1'b0;
    // Walk from the farthest offset down so the nearest one to ptr is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[ptr + indice_t'(k)]) begin
        vencedor = ptr + indice_t'(k);
        valido   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_serial_arbitro.sv
// Shares one tx_serial_8O1 transmitter among four byte requesters: fair pick, byte latch,
// start pulse, wait for end-of-frame with timeout, then ack or erro to the served unit.
module tx_serial_arbitro
  import tx_serial_arbitro_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  tx_serial_arbitro_if.master bus,
  output logic                ocupado,
  output logic [3:0]          db_estado
);

  localparam int            CW      = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CICLOS - 1);

  estado_t             estado, estado_n;
  indice_t             ptr, ptr_n;
  indice_t             sel, sel_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [7:0]          dados_q, dados_n;
  logic [NUM_REQ-1:0]  grant_q, grant_n;
  logic [NUM_REQ-1:0]  ack_q, ack_n;
  logic [NUM_REQ-1:0]  erro_q, erro_n;
  logic                partida_q, partida_n;
  logic                ocupado_q, ocupado_n;
  logic [3:0]          db_q, db_n;

  indice_t             vencedor;
  logic                valido;

  arbitro_rr_sel u_sel (
    .req      (bus.req),
    .ptr      (ptr),
    .vencedor (vencedor),
    .valido   (valido)
  );

  always_comb begin
    estado_n  = estado;
    ptr_n     = ptr;
    sel_n     = sel;
    cnt_n     = cnt;
    dados_n   = dados_q;
    grant_n   = grant_q;
    ack_n     = '0;
    erro_n    = '0;
    partida_n = 1'b0;

    case (estado)
      OCIOSO: begin
        if (valido) begin
          sel_n     = vencedor;
          dados_n   = bus.dados[{vencedor, 3'b000} +: 8];
          grant_n   = um_quente(vencedor);
          partida_n = 1'b1;
          estado_n  = PARTIDA;
        end
      end
      PARTIDA: begin
        cnt_n    = '0;
        estado_n = ESPERA;
      end
      ESPERA: begin
        // End of frame beats the timeout when both land on the same cycle.
        if (bus.tx_pronto) begin
          ack_n    = um_quente(sel);
          estado_n = FIM;
        end else if (cnt == CNT_MAX) begin
          erro_n   = um_quente(sel);
          estado_n = ERRO;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      FIM, ERRO: begin
        ptr_n    = sel + indice_t'(1);
        grant_n  = '0;
        estado_n = OCIOSO;
      end
      default: estado_n = OCIOSO;
    endcase

    // Moore outputs are registered from the upcoming state so they align with it.
    ocupado_n = (estado_n != OCIOSO);
    db_n      = estado_n;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= OCIOSO;
      ptr       <= '0;
      sel       <= '0;
      cnt       <= '0;
      dados_q   <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      erro_q    <= '0;
      partida_q <= 1'b0;
      ocupado_q <= 1'b0;
      db_q      <= '0;
    end else begin
      estado    <= estado_n;
      ptr       <= ptr_n;
      sel       <= sel_n;
      cnt       <= cnt_n;
      dados_q   <= dados_n;
      grant_q   <= grant_n;
      ack_q     <= ack_n;
      erro_q    <= erro_n;
      partida_q <= partida_n;
      ocupado_q <= ocupado_n;
      db_q      <= db_n;
    end
  end

  assign bus.tx_partida = partida_q;
  assign bus.tx_dados   = dados_q;
  assign bus.grant      = grant_q;
  assign bus.ack        = ack_q;
  assign bus.erro       = erro_q;
  assign ocupado        = ocupado_q;
  assign db_estado      = db_q;

endmodule

// File: doc/tx_serial_arbitro.md
# tx_serial_arbitro

Round-robin arbiter and sequencer that shares one `tx_serial_8O1` transmitter among four byte requesters. It sits between the requesting units (sensor readout, status reporter, debug dump, command echo) and the transmitter's `partida`/`dados_ascii`/`pronto` handshake. For each transmission it:
- picks one requester fairly;
- latches that requester's byte;
- pulses the transmitter start;
- waits for frame completion, with a timeout;
- acknowledges the requester.

## Interface
- `NUM_REQ`, 4, number of requesters (fixed at 4 in this revision).
- `TIMEOUT_CICLOS`, 65536, maximum number of cycles spent in ESPERA waiting for `tx_pronto` (covers one 11-bit frame at 9600 baud from 50 MHz, which is 57288 cycles).

Ports:
- `clock`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  4  per-requester transmit request, level. Held high until `ack` or `erro` is received.
- `dados`  in  32  per-requester byte; requester i drives bits [8i+7:8i].
- `tx_pronto`  in  1  one-cycle end-of-frame pulse from the transmitter.
- `tx_partida`  out  1  one-cycle start pulse to the transmitter.
- `tx_dados`  out  8  latched byte to the transmitter.
- `grant`  out  4  one-hot indicator of the requester currently being served; 0 when idle.
- `ack`  out  4  one-cycle pulse on the served requester's bit when its frame completes.
- `erro`  out  4  one-cycle pulse on the served requester's bit when the timeout expires.
- `ocupado`  out  1  high in every state except OCIOSO.
- `db_estado`  out  4  state code, for the `hexa7seg` display.

## Operation
State codes: OCIOSO=0, PARTIDA=1, ESPERA=2, FIM=3, ERRO=4. Outputs are Moore, driven from registers.

- **OCIOSO**
  - If `req` is non-zero: select the winner by scanning from index `ptr` upward with wrap-around. Latch the winner's byte into `tx_dados` and its index into `sel`, set `grant`, and go to PARTIDA.
  - Otherwise stay in OCIOSO.
- **PARTIDA**
  - `tx_partida`=1 for exactly this cycle.
  - Clear the timeout counter and go to ESPERA.
- **ESPERA**
  - If `tx_pronto`=1: go to FIM.
  - Else if the counter equals `TIMEOUT_CICLOS`-1: go to ERRO.
  - Else increment the counter.
  - If `tx_pronto` and the timeout occur in the same cycle, `tx_pronto` wins.
- **FIM**
  - `ack[sel]`=1 for this cycle.
  - `ptr` ← `sel`+1 mod 4. Clear `grant` and go to OCIOSO.
- **ERRO**
  - `erro[sel]`=1 for this cycle.
  - `ptr` ← `sel`+1 mod 4. Clear `grant` and go to OCIOSO.

Handshake and data rules:
- The byte is sampled only on the grant cycle. Requester data may change afterwards.
- If `req` drops after the grant, the frame still completes and `ack` is still issued.
- If `req` drops before the grant, that requester is not served.
- `tx_pronto` is ignored in OCIOSO, PARTIDA, FIM and ERRO.
- The timeout counter is ⌈log2(`TIMEOUT_CICLOS`)⌉ bits wide and never wraps, because it is cleared on entry to ESPERA.
- `tx_dados` holds its value after FIM/ERRO until the next grant.

Reset values:
- State OCIOSO, `ptr`=0, `sel`=0, counter=0.
- `tx_partida`=0, `tx_dados`=0x00, `grant`=0, `ack`=0, `erro`=0, `ocupado`=0, `db_estado`=0.
- Reset takes priority in any state. A frame in progress is abandoned with no `ack`/`erro`. The transmitter is reset by the same `reset` line at top level.

## Timing
- Request seen in OCIOSO at cycle t → `grant`/`tx_dados` valid and `tx_partida`=1 at t+1 → ESPERA from t+2.
- `tx_pronto` at cycle p (in ESPERA) → `ack` at p+1 → OCIOSO at p+2. A pending request is granted in that same OCIOSO cycle, so `tx_partida` occurs at p+3.
- No `tx_pronto` → `erro` at t+2+`TIMEOUT_CICLOS`.
- Minimum spacing between consecutive `tx_partida` pulses: 4 cycles plus the frame time.
- Fairness: a continuously requesting unit waits at most 3 other frames.

## Structure
- Package `tx_serial_arbitro_pkg`:
  - state encoding constants (OCIOSO..ERRO);
  - `NUM_REQ`;
  - the default `TIMEOUT_CICLOS`.
- Sub-module `arbitro_rr_sel`: purely combinational.
  - Inputs: `req[3:0]`, `ptr[1:0]`.
  - Outputs: winner index [1:0] and `valido`.
- Top level: FSM, byte/index/`ptr` registers, timeout counter.
- The `db_estado` output feeds an external `hexa7seg`.

## Test plan
All scenarios use `TIMEOUT_CICLOS`=64 and a bench model that pulses `tx_pronto` N cycles after `tx_partida`.

1. **Single request.** `req`=0010, `dados[15:8]`=0x41, N=20. Expect `tx_partida` one cycle at t+1, `tx_dados`=0x41, `grant`=0010, `ack`=0010 exactly one cycle after `tx_pronto`, and `ocupado` low after FIM.
2. **All requests after reset.** `req`=1111, bytes 0x30..0x33. Expect service order 0,1,2,3 with `tx_dados` 0x30,0x31,0x32,0x33, one `ack` per requester. Holding `req` high then continues with 0,1,…
3. **Fairness.** `req[0]` held continuously and `req[2]` held. Expect grants alternate 0001, 0100, 0001, 0100.
4. **Timeout.** `tx_pronto` never arrives. Expect `erro[sel]` exactly 66 cycles after the grant-request cycle, no `ack`, return to OCIOSO, and `ptr` advanced.
5. **Reset mid-ESPERA.** Expect all outputs at reset values on the next cycle, no `ack`/`erro`. A subsequent `req`=1000 is served first (`ptr` reset to 0 with no lower requesters).
6. **Edge events.** `tx_pronto` pulsed in OCIOSO produces no response. `tx_pronto` on the final timeout cycle produces `ack`, not `erro`. `req` withdrawn after grant still produces `ack`.
